// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset sequencer.
package multicycle_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FN_W     = 6;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FN_W-1:0] F_ADD  = 6'h20;
  localparam logic [FN_W-1:0] F_ADDU = 6'h21;
  localparam logic [FN_W-1:0] F_SUB  = 6'h22;
  localparam logic [FN_W-1:0] F_AND  = 6'h24;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0010;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXECUTE, MEM_RD, MEM_WR, WB_ALU, WB_MEM, HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_NONE, CL_RTYPE, CL_ADDI, CL_LW, CL_SW
  } iclass_e;

endpackage

// File: rtl/multicycle_ctrl_class_decode.sv
// Combinational opcode/funct classifier: instruction class, ALU op and legality.
module ctrl_class_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]     opcode,
  input  logic [FN_W-1:0]     funct,
  output iclass_e             iclass_c,
  output logic [ALU_OP_W-1:0] alu_op_c,
  output logic                legal_c
);

  always_comb begin
    iclass_c = CL_NONE;
    alu_op_c = ALU_ADD;
    legal_c  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU: begin iclass_c = CL_RTYPE; alu_op_c = ALU_ADD; legal_c = 1'b1; end
          F_SUB:         begin iclass_c = CL_RTYPE; alu_op_c = ALU_SUB; legal_c = 1'b1; end
          F_AND:         begin iclass_c = CL_RTYPE; alu_op_c = ALU_AND; legal_c = 1'b1; end
          default:       ;
        endcase
      end
      OP_ADDI: begin iclass_c = CL_ADDI; legal_c = 1'b1; end
      OP_LW:   begin iclass_c = CL_LW;   legal_c = 1'b1; end
      OP_SW:   begin iclass_c = CL_SW;   legal_c = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: steps instructions through fetch/decode/execute/mem/wb
// and arbitrates the shared memory port with a bounded req/ready handshake.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [31:0]         instr,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                i_or_d,
  output logic                ir_load,
  output logic                pc_en,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                alu_src_imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_to_reg,
  output logic                busy,
  output logic                illegal,
  output logic                bus_err,
  output logic [CNT_W-1:0]    retired
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e              state;
  state_e              nxt;
  iclass_e             cls;
  logic [TO_W-1:0]     tcnt;

  iclass_e             iclass_c;
  logic [ALU_OP_W-1:0] alu_op_c;
  logic                legal_c;
  logic                mem_state_c;
  logic                timeout_c;
  logic                retire_c;
  logic                unused_instr_bits;

  ctrl_class_decode u_dec (
    .opcode   (instr[31:26]),
    .funct    (instr[5:0]),
    .iclass_c (iclass_c),
    .alu_op_c (alu_op_c),
    .legal_c  (legal_c)
  );

  // Register/immediate fields are consumed by the datapath, not by the sequencer.
  assign unused_instr_bits = ^instr[25:6];

  assign mem_state_c = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timeout_c   = mem_state_c && !mem_ready && (tcnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign retire_c    = (state == WB_ALU) || (state == WB_MEM) || ((state == MEM_WR) && mem_ready);

  // IR/PC updates coincide with the fetch handshake completing.
  assign ir_load = (state == FETCH) && mem_ready;
  assign pc_en   = (state == FETCH) && mem_ready;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (run) nxt = FETCH;
      FETCH:   if (mem_ready) nxt = DECODE;
               else if (timeout_c) nxt = HALT;
      DECODE:  nxt = legal_c ? EXECUTE : IDLE;
      EXECUTE: begin
        case (cls)
          CL_LW:   nxt = MEM_RD;
          CL_SW:   nxt = MEM_WR;
          default: nxt = WB_ALU;
        endcase
      end
      MEM_RD:  if (mem_ready) nxt = WB_MEM;
               else if (timeout_c) nxt = HALT;
      MEM_WR:  if (mem_ready) nxt = IDLE;
               else if (timeout_c) nxt = HALT;
      WB_ALU:  nxt = IDLE;
      WB_MEM:  nxt = IDLE;
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cls         <= CL_NONE;
      tcnt        <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      i_or_d      <= 1'b0;
      reg_write   <= 1'b0;
      mem_to_reg  <= 1'b0;
      busy        <= 1'b0;
      alu_op      <= ALU_ADD;
      alu_src_imm <= 1'b0;
      reg_dst     <= 1'b0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
      retired     <= '0;
    end else begin
      state      <= nxt;
      tcnt       <= (mem_state_c && !mem_ready && (nxt == state)) ? tcnt + TO_W'(1) : '0;
      mem_req    <= (nxt == FETCH) || (nxt == MEM_RD) || (nxt == MEM_WR);
      mem_we     <= (nxt == MEM_WR);
      i_or_d     <= (nxt == MEM_RD) || (nxt == MEM_WR);
      reg_write  <= (nxt == WB_ALU) || (nxt == WB_MEM);
      mem_to_reg <= (nxt == WB_MEM);
      busy       <= (nxt != IDLE) && (nxt != HALT);

      // Datapath selects latch at decode and hold until the instruction ends.
      if ((state == DECODE) && legal_c) begin
        cls         <= iclass_c;
        alu_op      <= alu_op_c;
        alu_src_imm <= (iclass_c != CL_RTYPE);
        reg_dst     <= (iclass_c == CL_RTYPE);
      end else if (nxt == IDLE) begin
        cls         <= CL_NONE;
        alu_op      <= ALU_ADD;
        alu_src_imm <= 1'b0;
        reg_dst     <= 1'b0;
      end

      if ((state == DECODE) && !legal_c) illegal <= 1'b1;
      if (timeout_c) bus_err <= 1'b1;
      if (retire_c) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions with hand-computed strobe timing.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] instr;
  logic        mem_ready;
  logic        mem_req, mem_we, i_or_d, ir_load, pc_en, reg_write, reg_dst;
  logic        alu_src_imm, mem_to_reg, busy, illegal, bus_err;
  logic [3:0]  alu_op;
  logic [31:0] retired;

  multicycle_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_load(ir_load),
    .pc_en(pc_en), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
    .busy(busy), .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_FETCH, EV_RW, EV_MW} ev_e;
  typedef struct {
    ev_e        kind;
    int         cycle;
    logic [3:0] aop;
    logic       rdst;
    logic       m2r;
    logic       imm;
  } ev_t;

  // kind: 0 illegal, 1 register write-back, 2 memory write
  typedef struct {
    logic [31:0] ins;
    int          nwait;
    int          ncyc;
    logic [3:0]  aop;
    logic        rdst;
    logic        m2r;
    logic        imm;
    int          kind;
    int          nrd;
    int          nwe;
  } vec_t;

  ev_t  expq[$];
  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;
  int   t0 = 0;
  int   n_rd, n_we, n_rw;
  int   exp_ret;
  logic exp_ill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input ev_e k, input int c, input logic [3:0] a,
                         input logic rd, input logic m, input logic im);
    ev_t e;
    e.kind = k; e.cycle = c; e.aop = a; e.rdst = rd; e.m2r = m; e.imm = im;
    expq.push_back(e);
  endtask

  task automatic mon_event(input ev_e k);
    ev_t e;
    if (expq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", k, cyc - t0 + 1);
    end else begin
      e = expq.pop_front();
      check("ev_kind", 32'(k), 32'(e.kind));
      check("ev_cycle", 32'(cyc - t0 + 1), 32'(e.cycle));
      case (k)
        EV_FETCH: check("fetch_strobes", 32'({ir_load, pc_en, mem_req, i_or_d, mem_we}), 32'(5'b11100));
        EV_RW: begin
          check("wb_alu_op", 32'(alu_op), 32'(e.aop));
          check("wb_sel", 32'({reg_dst, mem_to_reg, alu_src_imm, mem_req}),
                32'({e.rdst, e.m2r, e.imm, 1'b0}));
        end
        default: begin
          check("mw_alu_op", 32'(alu_op), 32'(e.aop));
          check("mw_sel", 32'({alu_src_imm, i_or_d, reg_write}), 32'({e.imm, 1'b1, 1'b0}));
        end
      endcase
    end
  endtask

  // Monitor: consumes one expected event whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (ir_load || pc_en) mon_event(EV_FETCH);
      if (reg_write) mon_event(EV_RW);
      if (mem_req && mem_we && mem_ready) mon_event(EV_MW);
    end
  end

  task automatic run_instr(input logic [31:0] ins, input int nwait, output int ncyc);
    int n;
    n_rd = 0; n_we = 0; n_rw = 0; ncyc = -1;
    @(posedge clk); #1;
    t0 = cyc; run = 1'b1; instr = ins; mem_ready = 1'b1; n = 1;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      run = 1'b0;
      mem_ready = !(nwait > 0 && n >= 5 && n < 5 + nwait);
      @(negedge clk);
      if (mem_req && i_or_d) n_rd++;
      if (mem_we) n_we++;
      if (reg_write) n_rw++;
      if (!busy) begin
        ncyc = n - 1;
        break;
      end
    end
    if (ncyc < 0) begin
      tests++;
      fails++;
      $display("FAIL instr_done: got no return to IDLE within 40 cycles expected completion");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by t=%0t expected earlier end", $time);
    $fatal(1);
  end

  initial begin
    int   nc;
    vec_t v;
    rst = 1'b1; run = 1'b0; instr = 32'h0; mem_ready = 1'b0;
    #1;
    check("rst_strobes", 32'({mem_req, mem_we, i_or_d, ir_load, pc_en, reg_write, busy}), 32'(0));
    check("rst_selects", 32'({reg_dst, alu_src_imm, mem_to_reg, alu_op}), 32'(0));
    check("rst_sticky", 32'({illegal, bus_err}), 32'(0));
    check("rst_retired", retired, 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    vq.push_back('{32'h012A4020, 0, 5, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 0, 0}); // add
    vq.push_back('{32'h012A4021, 0, 5, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 0, 0}); // addu
    vq.push_back('{32'h012A4022, 0, 5, 4'b0001, 1'b1, 1'b0, 1'b0, 1, 0, 0}); // sub
    vq.push_back('{32'h012A4024, 0, 5, 4'b0010, 1'b1, 1'b0, 1'b0, 1, 0, 0}); // and
    vq.push_back('{32'h21280005, 0, 5, 4'b0000, 1'b0, 1'b0, 1'b1, 1, 0, 0}); // addi
    vq.push_back('{32'h8D280004, 3, 9, 4'b0000, 1'b0, 1'b1, 1'b1, 1, 4, 0}); // lw, 3 waits
    vq.push_back('{32'h8D280004, 0, 6, 4'b0000, 1'b0, 1'b1, 1'b1, 1, 1, 0}); // lw, no wait
    vq.push_back('{32'hAD280004, 0, 5, 4'b0000, 1'b0, 1'b0, 1'b1, 2, 1, 1}); // sw
    vq.push_back('{32'hAD280004, 2, 7, 4'b0000, 1'b0, 1'b0, 1'b1, 2, 3, 3}); // sw, 2 waits
    vq.push_back('{32'h012A4025, 0, 3, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, 0}); // or: illegal
    vq.push_back('{32'hFC000000, 0, 3, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, 0}); // bad opcode

    exp_ret = 0;
    exp_ill = 1'b0;
    foreach (vq[i]) begin
      v = vq[i];
      push_ev(EV_FETCH, 2, 4'b0, 1'b0, 1'b0, 1'b0);
      if (v.kind == 1) push_ev(EV_RW, v.ncyc, v.aop, v.rdst, v.m2r, v.imm);
      if (v.kind == 2) push_ev(EV_MW, v.ncyc, v.aop, v.rdst, v.m2r, v.imm);
      run_instr(v.ins, v.nwait, nc);
      if (v.kind != 0) exp_ret++;
      else exp_ill = 1'b1;
      check($sformatf("cycles_%08h", v.ins), 32'(nc), 32'(v.ncyc));
      check($sformatf("data_req_%08h", v.ins), 32'(n_rd), 32'(v.nrd));
      check($sformatf("mem_we_%08h", v.ins), 32'(n_we), 32'(v.nwe));
      check($sformatf("reg_write_%08h", v.ins), 32'(n_rw), 32'(v.kind == 1));
      check($sformatf("retired_%08h", v.ins), retired, 32'(exp_ret));
      check($sformatf("illegal_%08h", v.ins), 32'(illegal), 32'(exp_ill));
    end
    check("queue_drained", 32'(expq.size()), 32'(0));

    // Fetch never acknowledged: 16 waiting cycles, then HALT with bus_err.
    @(posedge clk); #1;
    t0 = cyc; run = 1'b1; instr = 32'h012A4020; mem_ready = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("to_before", 32'({bus_err, busy, mem_req}), 32'(3'b011));
    @(posedge clk); #1;
    check("to_halt", 32'({bus_err, busy, mem_req}), 32'(3'b100));
    run = 1'b1; mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("halt_sticky", 32'({bus_err, busy, mem_req, ir_load, reg_write}), 32'(5'b10000));
    check("halt_retired", retired, 32'(exp_ret));
    run = 1'b0;

    rst = 1'b1;
    #3;
    check("rst2_clears", 32'({bus_err, illegal, busy}), 32'(0));
    check("rst2_retired", retired, 32'(0));
    @(posedge clk); #1 rst = 1'b0;

    push_ev(EV_FETCH, 2, 4'b0, 1'b0, 1'b0, 1'b0);
    push_ev(EV_RW, 5, 4'b0000, 1'b1, 1'b0, 1'b0);
    run_instr(32'h012A4020, 0, nc);
    check("post_rst_retired", retired, 32'(1));

    // Reset landing in WB_ALU drops the write strobe without a clock edge.
    push_ev(EV_FETCH, 2, 4'b0, 1'b0, 1'b0, 1'b0);
    push_ev(EV_RW, 5, 4'b0010, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    t0 = cyc; run = 1'b1; instr = 32'h012A4024; mem_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      run = 1'b0;
    end
    @(negedge clk);
    check("wb_before_rst", 32'({reg_write, busy, reg_dst}), 32'(3'b111));
    #2 rst = 1'b1;
    #1;
    check("async_rst_strobes", 32'({reg_write, busy, mem_req, reg_dst, alu_op}), 32'(0));
    check("async_rst_retired", retired, 32'(0));
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst", 32'({busy, mem_req, reg_write}), 32'(0));
    check("retired_after_rst", retired, 32'(0));
    check("queue_final", 32'(expq.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS-subset core: add, addu, sub, and, addi, lw, sw.
- Steps each instruction through FETCH, DECODE, EXECUTE, optional MEM, and WRITEBACK.
- Drives the datapath enables and the ALU/mux selects, and arbitrates the single shared memory port between instruction fetch and data access using a req/ready handshake.
- Sits between the top-level core wrapper and the register file, ALU and unified memory.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles mem_req may wait for mem_ready before a bus error is raised.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  permits a new fetch; sampled only in IDLE.
- instr  input  32  instruction register contents, valid from DECODE onward.
- mem_ready  input  1  memory accepted or completed the current access.
- mem_req  output  1  memory access request; held until mem_ready.
- mem_we  output  1  access is a write (sw only).
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALU result.
- ir_load  output  1  latch mem_rdata into IR.
- pc_en  output  1  PC <= PC + 4.
- reg_write  output  1  register file write strobe.
- reg_dst  output  1  destination select: 1 = rd, 0 = rt.
- alu_src_imm  output  1  ALU B operand: 1 = sign-extended imm, 0 = rt.
- alu_op  output  4  0000 add, 0001 sub, 0010 and.
- mem_to_reg  output  1  write-back data select: 1 = memory data, 0 = ALU result.
- busy  output  1  high in every state except IDLE and HALT.
- illegal  output  1  sticky: an unsupported opcode/funct was decoded.
- bus_err  output  1  sticky: a memory handshake timed out.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset values:
  - State IDLE.
  - All strobes 0, all selects 0, alu_op 0000.
  - illegal = 0, bus_err = 0, retired = 0.
  - Timeout counter cleared.
- Strobe outputs (mem_req, ir_load, pc_en, reg_write) are Moore outputs of the current state, except ir_load/pc_en, which qualify on mem_ready.
- IDLE:
  - run = 1 -> FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - mem_req = 1, i_or_d = 0, mem_we = 0.
  - On mem_ready = 1: ir_load = 1 and pc_en = 1 in that same cycle, then -> DECODE.
- DECODE: classify instr[31:26] and instr[5:0].
  - opcode 0 with funct 0x20/0x21 -> add; 0x22 -> sub; 0x24 -> and.
  - opcode 0x08 addi, 0x23 lw, 0x2B sw.
  - Anything else: set illegal, -> IDLE; nothing is retired and no write occurs.
- EXECUTE: alu_op, alu_src_imm and reg_dst are driven per class and held stable through WRITEBACK.
  - R-type: -> WB_ALU.
  - addi: -> WB_ALU.
  - lw: -> MEM_RD.
  - sw: -> MEM_WR.
- MEM_RD:
  - mem_req = 1, i_or_d = 1, mem_we = 0.
  - On mem_ready -> WB_MEM.
- MEM_WR:
  - mem_req = 1, i_or_d = 1, mem_we = 1.
  - On mem_ready: retire, -> IDLE.
- WB_ALU: reg_write = 1, mem_to_reg = 0; retire; -> IDLE.
- WB_MEM: reg_write = 1, mem_to_reg = 1, reg_dst = 0; retire; -> IDLE.
- Retire means retired += 1; the counter wraps modulo 2^CNT_W.
- Cycles per instruction with zero memory wait: R-type/addi 5, lw 6, sw 5, IDLE cycle included.
- Timeout:
  - The counter increments each cycle mem_req = 1 and mem_ready = 0, and clears on mem_ready or on leaving the state.
  - Reaching TIMEOUT_CYCLES: set bus_err, -> HALT.
  - HALT: all strobes 0; the only exit is rst.
- mem_ready while mem_req = 0 is ignored.
- run deasserting mid-instruction does not abort; the current instruction completes.
- rst asserted in any state forces reset values immediately. A pending write strobe is dropped in the cycle it is asserted.
- illegal and bus_err clear only on rst.

Decomposition:
- Shared package holds:
  - Opcode constants: OP_RTYPE = 0x00, OP_ADDI = 0x08, OP_LW = 0x23, OP_SW = 0x2B.
  - Funct constants: F_ADD = 0x20, F_ADDU = 0x21, F_SUB = 0x22, F_AND = 0x24.
  - ALU op encodings: ALU_ADD, ALU_SUB, ALU_AND.
  - State enum: IDLE, FETCH, DECODE, EXECUTE, MEM_RD, MEM_WR, WB_ALU, WB_MEM, HALT.
  - Instruction-class enum.
- One sub-module, ctrl_class_decode: combinational instr -> {class, alu_op, legal}.
- The FSM, timeout counter and retire counter remain in multicycle_ctrl.

Test Plan:
- rst, run = 1, instr = 0x012A4020 (add $8,$9,$10), mem_ready = 1 always:
  - ir_load and pc_en pulse in cycle 2.
  - alu_op = 0000, reg_dst = 1; reg_write pulses in cycle 5.
  - retired = 1.
- lw 0x8D280004, mem_ready delayed 3 cycles in MEM_RD:
  - mem_req held with i_or_d = 1 for 4 cycles.
  - reg_write with mem_to_reg = 1, reg_dst = 0.
  - 9 cycles total.
- sw 0xAD280004:
  - mem_we = 1 only in MEM_WR; reg_write never asserts.
  - retired increments on mem_ready.
- instr = 0x012A4025 (or, funct 0x25): illegal = 1, no reg_write, retired unchanged, FSM returns to IDLE.
- mem_ready held 0 in FETCH: after 16 cycles bus_err = 1, FSM in HALT, busy = 0; run is ignored until rst.
- rst asserted during WB_ALU: reg_write drops asynchronously; all outputs return to reset values; retired = 0.
